// File: rtl/zmod_pkg.sv
// rtl/zmod_pkg.sv - shared sample width, Q2.14 constants and conditioner FSM states
package zmod_pkg;

    localparam int ZMOD_DATA_SIZE = 14;
    localparam int FRAC_BITS      = 14;
    localparam int ONE            = 16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sample_conditioner_sat_round.sv
// rtl/sample_conditioner_sat_round.sv - Q2.14 round-half-up, shift down and saturate to OUT_W bits
module sat_round #(
    parameter int IN_W  = 31,
    parameter int OUT_W = 14
) (
    input  logic signed [IN_W-1:0]  i_p,
    output logic signed [OUT_W-1:0] o_r,
    output logic                    o_sat
);
    import zmod_pkg::*;

    localparam int SUM_W = IN_W + 1;
    localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [OUT_W-1:0] OUT_MAX = SAT_MAX[OUT_W-1:0];
    localparam logic signed [OUT_W-1:0] OUT_MIN = SAT_MIN[OUT_W-1:0];

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_q;
    logic                    w_hi;
    logic                    w_lo;

    // One guard bit keeps the rounding add from wrapping at the product extreme
    assign w_sum = SUM_W'(i_p) + ROUND;
    assign w_q   = w_sum >>> FRAC_BITS;
    assign w_hi  = (w_q > SAT_MAX);
    assign w_lo  = (w_q < SAT_MIN);
    assign o_sat = w_hi | w_lo;
    assign o_r   = w_hi ? OUT_MAX : (w_lo ? OUT_MIN : w_q[OUT_W-1:0]);

endmodule

// File: rtl/sample_conditioner.sv
// rtl/sample_conditioner.sv - ADC offset calibration plus 3-stage offset/gain/saturate pipeline
// Optional saturation counter built only with SAMPLE_CONDITIONER_SAT_CNT_EN defined.
module sample_conditioner #(
    parameter int ZMOD_DATA_SIZE = zmod_pkg::ZMOD_DATA_SIZE,
    parameter int CAL_LOG2       = 8,
    parameter int GAIN_WIDTH     = 16
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_init_done,
    input  logic                             i_valid,
    input  logic signed [ZMOD_DATA_SIZE-1:0] i_data,
    input  logic                             i_cal_start,
    input  logic signed [GAIN_WIDTH-1:0]     i_gain,
    output logic signed [ZMOD_DATA_SIZE-1:0] o_data,
    output logic                             o_valid,
    output logic signed [ZMOD_DATA_SIZE-1:0] o_offset,
    output logic                             o_cal_done,
    output logic                             o_busy,
    output logic [15:0]                      o_sat_count
);
    import zmod_pkg::*;

    localparam int N     = ZMOD_DATA_SIZE;
    localparam int D_W   = N + 1;
    localparam int ACC_W = N + CAL_LOG2;
    localparam int P_W   = D_W + GAIN_WIDTH;

    logic [1:0]               r_rst_sync;
    logic                     w_rst_n;
    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [CAL_LOG2-1:0]      r_cnt;
    logic signed [N-1:0]      r_offset;
    logic                     r_cal_done;
    logic                     r_busy;
    logic signed [D_W-1:0]    r_s1_d;
    logic                     r_s1_valid;
    logic signed [P_W-1:0]    r_s2_p;
    logic                     r_s2_valid;
    logic signed [N-1:0]      w_s3_r;
    logic                     w_s3_sat;
    logic signed [N-1:0]      r_data;
    logic                     r_valid;

    // Assert asynchronously, release two clock edges after i_reset rises
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n    = r_rst_sync[1];
    assign w_acc_next = r_acc + ACC_W'(i_data);

    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_offset   <= '0;
            r_cal_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_init_done) begin
                        r_state <= CAL;
                        r_busy  <= 1'b1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CAL: begin
                    if (!i_init_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CAL_LOG2'(1);
                        // Top N bits of the running sum are the arithmetic mean
                        if (&r_cnt) begin
                            r_offset   <= w_acc_next[ACC_W-1:CAL_LOG2];
                            r_state    <= RUN;
                            r_busy     <= 1'b0;
                            r_cal_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!i_init_done) begin
                        r_state    <= IDLE;
                        r_cal_done <= 1'b0;
                    end else if (i_cal_start) begin
                        r_state    <= CAL;
                        r_busy     <= 1'b1;
                        r_cal_done <= 1'b0;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_cal_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1_d     <= '0;
            r_s1_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_valid <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_s1_d     <= D_W'(i_data) - D_W'(r_offset);
            r_s1_valid <= i_valid;
            r_s2_p     <= P_W'(r_s1_d) * P_W'(i_gain);
            r_s2_valid <= r_s1_valid;
            r_valid    <= r_s2_valid;
            if (r_s2_valid) begin
                r_data <= w_s3_r;
            end
        end
    end

    sat_round #(
        .IN_W  (P_W),
        .OUT_W (N)
    ) u_sat_round (
        .i_p   (r_s2_p),
        .o_r   (w_s3_r),
        .o_sat (w_s3_sat)
    );

`ifdef SAMPLE_CONDITIONER_SAT_CNT_EN
    logic [15:0] r_sat_count;
    logic        w_cal_accept;

    assign w_cal_accept = (r_state == RUN) && i_init_done && i_cal_start;

    always_ff @(posedge i_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sat_count <= '0;
        end else if (w_cal_accept) begin
            r_sat_count <= '0;
        end else if (r_s2_valid && w_s3_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign o_sat_count = r_sat_count;
`else
    logic w_sat_unused;
    assign w_sat_unused = w_s3_sat;
    assign o_sat_count  = 16'd0;
`endif

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_offset   = r_offset;
    assign o_cal_done = r_cal_done;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_sample_conditioner.sv
// tb/tb_sample_conditioner.sv - self-checking bench for sample_conditioner
module tb_sample_conditioner;

`ifdef SAMPLE_CONDITIONER_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_init_done;
    logic               i_valid;
    logic signed [13:0] i_data;
    logic               i_cal_start;
    logic signed [15:0] i_gain;
    logic signed [13:0] o_data;
    logic               o_valid;
    logic signed [13:0] o_offset;
    logic               o_cal_done;
    logic               o_busy;
    logic [15:0]        o_sat_count;

    int total = 0;
    int bad   = 0;
    int exp_sat = 0;

    typedef struct {
        int data;
        int gain;
        int exp_data;
        bit exp_sat;
    } vec_t;

    vec_t tbl[12];
    int   rv[400];
    int   rd[400];
    int   rg[400];

    sample_conditioner dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_init_done (i_init_done),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_cal_start (i_cal_start),
        .i_gain      (i_gain),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_offset    (o_offset),
        .o_cal_done  (o_cal_done),
        .o_busy      (o_busy),
        .o_sat_count (o_sat_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: floor((d*g + 2^13) / 2^14), clipped to the 14-bit range
    function automatic void model(input int data, input int offs, input int gain,
                                  output int r, output bit s);
        longint p, num, q;
        p   = longint'(data - offs) * longint'(gain);
        num = p + 8192;
        q   = num / 16384;
        if ((num % 16384) != 0 && num < 0) q = q - 1;
        s = 1'b0;
        if (q > 8191) begin
            r = 8191;
            s = 1'b1;
        end else if (q < -8192) begin
            r = -8192;
            s = 1'b1;
        end else begin
            r = int'(q);
        end
    endfunction

    task automatic sat_expect_inc();
        if (exp_sat < 65535) exp_sat++;
    endtask

    task automatic feed_cal(input int val, input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            i_valid     = 1'b1;
            i_data      = 14'(val);
            i_cal_start = (i == pulse_at);
            check("busy_cal", o_busy, 1);
            step();
        end
        i_valid     = 1'b0;
        i_cal_start = 1'b0;
    endtask

    task automatic flush();
        i_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int ed;
        bit es;
        int hold;

        tbl[0]  = '{-3,     8192,  -1,    1'b0};
        tbl[1]  = '{3,      8192,  2,     1'b0};
        tbl[2]  = '{1000,   16384, 1000,  1'b0};
        tbl[3]  = '{5,     -16384, -5,    1'b0};
        tbl[4]  = '{1,      8191,  0,     1'b0};
        tbl[5]  = '{1,      8192,  1,     1'b0};
        tbl[6]  = '{-1,     8192,  0,     1'b0};
        tbl[7]  = '{8191,   16384, 8191,  1'b0};
        tbl[8]  = '{-8192,  16384, -8192, 1'b0};
        tbl[9]  = '{8191,   32767, 8191,  1'b1};
        tbl[10] = '{-8192,  32767, -8192, 1'b1};
        tbl[11] = '{-8192, -32768, 8191,  1'b1};

        i_reset     = 1'b0;
        i_init_done = 1'b0;
        i_valid     = 1'b0;
        i_data      = '0;
        i_cal_start = 1'b0;
        i_gain      = 16'sd16384;
        repeat (2) step();
        check("rst_data", o_data, 0);
        check("rst_valid", o_valid, 0);
        check("rst_offset", o_offset, 0);
        check("rst_cal_done", o_cal_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_sat", o_sat_count, 0);
        i_reset = 1'b1;
        repeat (3) step();

        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        check("idle_cal_start_ignored", o_busy, 0);

        // Offset is zero in IDLE, so vectors exercise the arithmetic directly
        for (int v = 0; v < 12; v++) begin
            i_valid = 1'b1;
            i_data  = 14'(tbl[v].data);
            i_gain  = 16'(tbl[v].gain);
            step();
            i_valid = 1'b0;
            step();
            step();
            check($sformatf("vec%0d_valid", v), o_valid, 1);
            check($sformatf("vec%0d_data", v), o_data, tbl[v].exp_data);
            step();
            check($sformatf("vec%0d_valid_low", v), o_valid, 0);
            check($sformatf("vec%0d_hold", v), o_data, tbl[v].exp_data);
            if (tbl[v].exp_sat) sat_expect_inc();
        end
        check("sat_after_table", o_sat_count, SAT_EN ? exp_sat : 0);

        i_gain      = 16'sd16384;
        i_init_done = 1'b1;
        step();
        feed_cal(100, 256, 128);
        check("cal_offset", o_offset, 100);
        check("cal_done", o_cal_done, 1);
        check("cal_busy_low", o_busy, 0);
        flush();

        i_valid = 1'b1;
        i_data  = 14'sd1100;
        step();
        i_valid = 1'b0;
        check("lat_t1", o_valid, 0);
        step();
        check("lat_t2", o_valid, 0);
        step();
        check("lat_t3", o_valid, 1);
        check("gain_unity", o_data, 1000);
        step();

        hold = 1000;
        for (int k = 0; k < 302; k++) begin
            if (k < 300) begin
                rv[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                rd[k] = int'($signed(14'($urandom)));
            end else begin
                rv[k] = 0;
                rd[k] = 0;
            end
            rg[k]   = int'($signed(16'($urandom)));
            i_valid = rv[k][0];
            i_data  = 14'(rd[k]);
            i_gain  = 16'(rg[k]);
            step();
            if (k >= 2) begin
                if (rv[k-2] != 0) begin
                    model(rd[k-2], 100, rg[k-1], ed, es);
                    hold = ed;
                    if (es) sat_expect_inc();
                end
                check("rand_valid", o_valid, rv[k-2]);
                check("rand_data", o_data, hold);
            end
        end
        i_valid = 1'b0;
        check("sat_after_rand", o_sat_count, SAT_EN ? exp_sat : 0);

        i_gain      = 16'sd0;
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        exp_sat     = 0;
        check("retrig_cal_done", o_cal_done, 0);
        check("retrig_busy", o_busy, 1);
        check("retrig_sat_clr", o_sat_count, 0);
        feed_cal(-8192, 256, -1);
        check("cal2_offset", o_offset, -8192);
        check("cal2_done", o_cal_done, 1);
        flush();

        i_gain  = 16'sd16384;
        i_valid = 1'b1;
        i_data  = 14'sd8191;
        step();
        i_valid = 1'b0;
        step();
        step();
        check("sat_valid", o_valid, 1);
        check("sat_data", o_data, 8191);
        check("sat_count", o_sat_count, SAT_EN ? 1 : 0);
        step();

        i_gain      = 16'sd0;
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        check("early_busy", o_busy, 1);
        feed_cal(500, 50, -1);
        i_init_done = 1'b0;
        step();
        check("early_busy_low", o_busy, 0);
        check("early_cal_done", o_cal_done, 0);
        check("early_offset", o_offset, -8192);
        repeat (3) step();
        check("early_offset_kept", o_offset, -8192);

        i_init_done = 1'b1;
        step();
        check("rcal_busy", o_busy, 1);
        feed_cal(100, 100, -1);
        i_reset = 1'b0;
        #1;
        check("mrst_data", o_data, 0);
        check("mrst_valid", o_valid, 0);
        check("mrst_offset", o_offset, 0);
        check("mrst_cal_done", o_cal_done, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_sat", o_sat_count, 0);
        repeat (2) step();
        check("mrst_hold_busy", o_busy, 0);
        i_reset = 1'b1;
        step();
        check("rel_e1_busy", o_busy, 0);
        step();
        check("rel_e2_busy", o_busy, 0);
        step();
        check("rel_e3_busy", o_busy, 1);
        i_gain = 16'sd16384;
        feed_cal(100, 256, -1);
        check("cal3_offset", o_offset, 100);
        check("cal3_done", o_cal_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_conditioner.md
SAMPLE_CONDITIONER -- requirements
Module: sample_conditioner

Interface
REQ-001 Parameter ZMOD_DATA_SIZE, default 14: sample width, two's complement.
REQ-002 Parameter CAL_LOG2, default 8: calibration averages 2^CAL_LOG2 samples.
REQ-003 Parameter GAIN_WIDTH, default 16: signed gain in Q2.14 format; 16384 = 1.0.
REQ-004 i_clock  in  1  single clock for the block; all logic is on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_init_done  in  1  the ADC path is initialised and its samples are meaningful.
REQ-007 i_valid  in  1  i_data is valid this cycle.
REQ-008 i_data  in  ZMOD_DATA_SIZE  signed ADC sample.
REQ-009 i_cal_start  in  1  single-cycle request to recalibrate the offset.
REQ-010 i_gain  in  GAIN_WIDTH  signed Q2.14 gain; sampled every cycle in pipeline stage 2.
REQ-011 o_data  out  ZMOD_DATA_SIZE  conditioned sample, for the DAC channel input.
REQ-012 o_valid  out  1  o_data is new this cycle.
REQ-013 o_offset  out  ZMOD_DATA_SIZE  offset currently being subtracted.
REQ-014 o_cal_done  out  1  high in RUN once at least one calibration has completed.
REQ-015 o_busy  out  1  high while in state CAL.
REQ-016 o_sat_count  out  16  count of saturated output samples (see Configuration).

Function
REQ-017 The FSM SHALL have three states: IDLE, CAL and RUN.
REQ-018 IDLE -> CAL when i_init_done=1; any state -> IDLE when i_init_done=0; RUN -> CAL on i_cal_start=1.
REQ-019 i_cal_start in IDLE or CAL SHALL be ignored.
REQ-020 CAL SHALL accumulate only samples with i_valid=1, into an accumulator of ZMOD_DATA_SIZE+CAL_LOG2 bits.
REQ-021 CAL entry SHALL clear the accumulator and the sample counter.
REQ-022 On the cycle the 2^CAL_LOG2-th sample is accepted, o_offset SHALL load acc>>>CAL_LOG2, including that sample, using an arithmetic shift.
REQ-023 That load SHALL take effect on the next cycle; the FSM SHALL go to RUN and set o_cal_done=1.
REQ-024 o_offset SHALL change only at that load (REQ-022) or at reset.
REQ-025 Leaving CAL early (i_init_done=0) SHALL discard the partial sum and keep the old o_offset.
REQ-026 The pipeline SHALL run in every state, using the current o_offset.
REQ-027 Stage 1: d = i_data - o_offset, ZMOD_DATA_SIZE+1 bits signed.
REQ-028 Stage 2: p = d * i_gain, full-width signed product.
REQ-029 Stage 3: r = (p + 2^13) >>> 14, saturated to [-2^(ZMOD_DATA_SIZE-1), 2^(ZMOD_DATA_SIZE-1)-1].
REQ-030 Latency SHALL be exactly 3 cycles: o_valid(t+3) = i_valid(t).
REQ-031 o_data SHALL hold its value when o_valid=0.
REQ-032 o_cal_done SHALL clear on RUN->CAL and on entry to IDLE.

Reset
REQ-033 While i_reset=0, all registers SHALL clear asynchronously.
REQ-034 Reset values: state=IDLE, o_data=0, o_valid=0, o_offset=0, o_cal_done=0, o_busy=0, o_sat_count=0, pipeline valids=0.
REQ-035 Reset release SHALL be synchronised internally, deasserting on an i_clock edge.

Configuration
REQ-036 With macro SAMPLE_CONDITIONER_SAT_CNT_EN defined, o_sat_count SHALL increment on each o_valid sample that saturated.
REQ-037 The counter SHALL stick at 0xFFFF and clear on an accepted i_cal_start.
REQ-038 Without the macro, o_sat_count SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-039 Shared package zmod_pkg SHALL hold ZMOD_DATA_SIZE, the Q2.14 constants (FRAC_BITS=14, ONE=16384) and the FSM state typedef.
REQ-040 Stage-3 round-and-saturate SHALL be a sub-module, sat_round, which also outputs a saturation flag.

Verification
REQ-041 Calibration: init_done=1, 256 valid samples of 100 -> o_busy high throughout, then o_offset=100, o_cal_done=1.
REQ-042 Gain: offset=100, gain=16384, i_data=1100 at cycle t -> o_data=1000 with o_valid at t+3.
REQ-043 Rounding: offset=0, gain=8192, i_data=-3 -> o_data=-1; with i_data=3 -> o_data=2.
REQ-044 Saturation: offset=-8192, gain=16384, i_data=8191 -> o_data=8191; o_sat_count=1 when the macro is defined, 0 when not.
REQ-045 Reset mid-calibration: reset asserted after 100 of 256 samples -> outputs at reset values immediately; the FSM returns to IDLE, then to CAL once reset is released with init_done=1.
REQ-046 Early exit and retrigger: init_done dropped mid-CAL -> IDLE with the old o_offset kept; i_cal_start in RUN -> o_cal_done=0 and o_busy=1 on the next cycle.
